// File: rtl/fanout_bcast_arbiter.sv
// ============================================================================
// Module   : fanout_bcast_arbiter
// Purpose  : Round-robin sharing of one registered high-fanout broadcast bit
//            (`a`) among NUM_REQ requesters. Each update is spread over
//            NUM_GROUPS load groups, one group enable per cycle, followed by
//            an optional settle window and a one-cycle `done` pulse.
// Options  : FANOUT_BCAST_STALL_EN adds a `stall` input that freezes the
//            SPREAD/SETTLE sequencing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fanout_bcast_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int NUM_GROUPS    = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk1,
    input  logic                  rst,
`ifdef FANOUT_BCAST_STALL_EN
    input  logic                  stall,
`endif
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_data,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  a,
    output logic [NUM_GROUPS-1:0] grp_en,
    output logic                  busy,
    output logic                  done
);

    // Counter widths: $clog2 of the bound, never narrower than one bit.
    localparam int PW = (NUM_REQ       > 1) ? $clog2(NUM_REQ)       : 1;
    localparam int GW = (NUM_GROUPS    > 1) ? $clog2(NUM_GROUPS)    : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [PW-1:0] REQ_LAST    = PW'(NUM_REQ - 1);
    localparam logic [GW-1:0] GRP_LAST    = GW'(NUM_GROUPS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SPREAD = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_ptr;
    logic [GW-1:0]   r_grp_idx;
    logic [SW-1:0]   r_settle_cnt;
    logic            w_any;
    logic [PW-1:0]   w_winner;
    logic [PW-1:0]   w_cand;
    logic            w_stall;

`ifdef FANOUT_BCAST_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    // Round-robin search: start just above the last winner and wrap once.
    always_comb begin
        w_any    = 1'b0;
        w_winner = r_ptr;
        w_cand   = r_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = (w_cand == REQ_LAST) ? '0 : w_cand + 1'b1;
            if (!w_any && req[w_cand]) begin
                w_any    = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs; a stalled cycle drops grp_en.
    always_comb begin
        w_state_next = r_state;
        grp_en       = '0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_next = S_SPREAD;
                end
            end
            S_SPREAD: begin
                busy = 1'b1;
                if (!w_stall) begin
                    grp_en = NUM_GROUPS'(1) << r_grp_idx;
                    if (r_grp_idx == GRP_LAST) begin
                        w_state_next = (SETTLE_CYCLES > 0) ? S_SETTLE : S_DONE;
                    end
                end
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (!w_stall && (r_settle_cnt == SETTLE_LAST)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Grant capture, broadcast register and sequencing counters.
    always_ff @(posedge clk1) begin
        if (rst) begin
            gnt          <= '0;
            a            <= 1'b0;
            r_ptr        <= REQ_LAST;
            r_grp_idx    <= '0;
            r_settle_cnt <= '0;
        end else begin
            gnt <= '0;
            case (r_state)
                S_IDLE: begin
                    r_settle_cnt <= '0;
                    if (w_any) begin
                        gnt       <= NUM_REQ'(1) << w_winner;
                        a         <= req_data[w_winner];
                        r_ptr     <= w_winner;
                        r_grp_idx <= '0;
                    end
                end
                S_SPREAD: begin
                    if (!w_stall) begin
                        r_grp_idx <= (r_grp_idx == GRP_LAST) ? '0 : r_grp_idx + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (!w_stall) begin
                        r_settle_cnt <= (r_settle_cnt == SETTLE_LAST) ? '0 : r_settle_cnt + 1'b1;
                    end
                end
                default: begin
                    r_grp_idx    <= '0;
                    r_settle_cnt <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fanout_bcast_arbiter.sv
// ============================================================================
// Module   : tb_fanout_bcast_arbiter
// Purpose  : Directed self-checking bench for fanout_bcast_arbiter. One DUT
//            uses default parameters, a second uses NUM_GROUPS=3 and
//            SETTLE_CYCLES=0. Stall cases run when FANOUT_BCAST_STALL_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fanout_bcast_arbiter;

    logic       clk1 = 1'b0;
    logic       rst  = 1'b1;

    logic [3:0] req0 = '0, data0 = '0, gnt0;
    logic       a0, busy0, done0;
    logic [1:0] grp_en0;
    logic       stall0 = 1'b0;

    logic [3:0] req1 = '0, data1 = '0, gnt1;
    logic       a1, busy1, done1;
    logic [2:0] grp_en1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk1 = ~clk1;

    fanout_bcast_arbiter u_dut0 (
        .clk1     (clk1),
        .rst      (rst),
`ifdef FANOUT_BCAST_STALL_EN
        .stall    (stall0),
`endif
        .req      (req0),
        .req_data (data0),
        .gnt      (gnt0),
        .a        (a0),
        .grp_en   (grp_en0),
        .busy     (busy0),
        .done     (done0)
    );

    fanout_bcast_arbiter #(
        .NUM_REQ       (4),
        .NUM_GROUPS    (3),
        .SETTLE_CYCLES (0)
    ) u_dut1 (
        .clk1     (clk1),
        .rst      (rst),
`ifdef FANOUT_BCAST_STALL_EN
        .stall    (1'b0),
`endif
        .req      (req1),
        .req_data (data1),
        .gnt      (gnt1),
        .a        (a1),
        .grp_en   (grp_en1),
        .busy     (busy1),
        .done     (done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] exp_order [5];
    int         gcount;
    int         last_c;
    int         dcount;

    initial begin
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset state
        do_reset();
        chk("rst_gnt",    gnt0,    4'b0000);
        chk("rst_a",      a0,      1'b0);
        chk("rst_grp_en", grp_en0, 2'b00);
        chk("rst_busy",   busy0,   1'b0);
        chk("rst_done",   done0,   1'b0);

        // Single request 0100 with data 1, default parameters
        req0 = 4'b0100; data0 = 4'b0100;
        tick(); // cycle 1
        chk("t1_c1_gnt",  gnt0,    4'b0100);
        chk("t1_c1_a",    a0,      1'b1);
        chk("t1_c1_en",   grp_en0, 2'b01);
        chk("t1_c1_busy", busy0,   1'b1);
        req0 = '0; data0 = '0;
        tick(); // cycle 2
        chk("t1_c2_gnt",  gnt0,    4'b0000);
        chk("t1_c2_en",   grp_en0, 2'b10);
        tick(); // cycle 3
        chk("t1_c3_en",   grp_en0, 2'b00);
        chk("t1_c3_busy", busy0,   1'b1);
        chk("t1_c3_done", done0,   1'b0);
        tick(); // cycle 4
        chk("t1_c4_en",   grp_en0, 2'b00);
        chk("t1_c4_done", done0,   1'b0);
        tick(); // cycle 5
        chk("t1_c5_done", done0,   1'b1);
        chk("t1_c5_busy", busy0,   1'b1);
        chk("t1_c5_a",    a0,      1'b1);
        tick(); // cycle 6
        chk("t1_c6_busy", busy0,   1'b0);
        chk("t1_c6_done", done0,   1'b0);

        // All requests held: round-robin order and 6-cycle spacing
        do_reset();
        req0 = 4'b1111;
        gcount = 0;
        last_c = -1;
        for (int c = 0; c < 40 && gcount < 5; c++) begin
            tick();
            if (gnt0 != 4'b0000) begin
                chk("rr_order", gnt0, exp_order[gcount]);
                if (gcount > 0) chk("rr_gap", c - last_c, 6);
                last_c = c;
                gcount++;
            end
        end
        chk("rr_count", gcount, 5);
        req0 = '0;

        // Reset during SPREAD with grp_idx=1
        do_reset();
        req0 = 4'b1001; data0 = 4'b0001;
        tick(); // cycle 1
        chk("rs_c1_gnt", gnt0,    4'b0001);
        tick(); // cycle 2
        chk("rs_c2_en",  grp_en0, 2'b10);
        rst = 1'b1;
        tick(); // cycle 3: reset taken
        rst = 1'b0;
        dcount = 0;
        chk("rs_gnt",    gnt0,    4'b0000);
        chk("rs_a",      a0,      1'b0);
        chk("rs_en",     grp_en0, 2'b00);
        chk("rs_busy",   busy0,   1'b0);
        chk("rs_done",   done0,   1'b0);
        tick(); // cycle 4: re-arbitrated from reset pointer
        chk("rs_regnt",  gnt0,    4'b0001);
        req0 = '0;
        for (int c = 5; c <= 7; c++) begin
            tick();
            if (done0) dcount++;
        end
        chk("rs_no_abort_done", dcount, 0);
        tick(); // cycle 8
        chk("rs_new_done", done0, 1'b1);
        tick();

        // NUM_GROUPS=3, SETTLE_CYCLES=0
        req1 = 4'b0010; data1 = 4'b0010;
        tick(); // cycle 1
        chk("g3_c1_gnt",  gnt1,    4'b0010);
        chk("g3_c1_a",    a1,      1'b1);
        chk("g3_c1_en",   grp_en1, 3'b001);
        req1 = '0; data1 = '0;
        tick();
        chk("g3_c2_en",   grp_en1, 3'b010);
        tick();
        chk("g3_c3_en",   grp_en1, 3'b100);
        chk("g3_c3_done", done1,   1'b0);
        tick();
        chk("g3_c4_done", done1,   1'b1);
        chk("g3_c4_en",   grp_en1, 3'b000);
        chk("g3_c4_busy", busy1,   1'b1);
        tick();
        chk("g3_c5_busy", busy1,   1'b0);

        // a is held while busy; requests pulsed while busy are lost
        do_reset();
        req0 = 4'b0010; data0 = 4'b0000;
        tick(); // cycle 1
        chk("hold_c1_gnt", gnt0, 4'b0010);
        chk("hold_c1_a",   a0,   1'b0);
        req0 = '0;
        tick(); // cycle 2
        req0 = 4'b0010; data0 = 4'b0010;
        tick(); // cycle 3
        req0 = '0; data0 = '0;
        dcount = 0;
        for (int c = 3; c <= 5; c++) begin
            chk("hold_a", a0, 1'b0);
            if (gnt0 != 4'b0000) dcount++;
            if (c < 5) tick();
        end
        chk("hold_c5_done", done0, 1'b1);
        for (int c = 6; c <= 9; c++) begin
            tick();
            if (gnt0 != 4'b0000) dcount++;
        end
        chk("hold_no_regrant", dcount, 0);
        chk("hold_a_idle",     a0,     1'b0);

`ifdef FANOUT_BCAST_STALL_EN
        // One stall cycle in cycle 2 of a default sequence
        do_reset();
        req0 = 4'b0100; data0 = 4'b0100;
        tick(); // cycle 1
        chk("st_c1_en", grp_en0, 2'b01);
        req0 = '0; data0 = '0;
        tick(); // cycle 2
        stall0 = 1'b1;
        #1;
        chk("st_c2_en",   grp_en0, 2'b00);
        chk("st_c2_busy", busy0,   1'b1);
        tick(); // cycle 3
        stall0 = 1'b0;
        #1;
        chk("st_c3_en", grp_en0, 2'b10);
        dcount = 3;
        for (int c = 4; c <= 6; c++) begin
            tick();
            if (busy0) dcount++;
            if (c < 6) chk("st_no_done", done0, 1'b0);
        end
        chk("st_c6_done", done0,  1'b1);
        chk("st_busy_cycles", dcount, 6);
        tick();
        chk("st_c7_busy", busy0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
